dash_warn_ctrl: RTL and testbench
=================================

Name: dash_warn_ctrl

Overview:
Parametrised, clocked dashboard indicator controller for N_SW raw switch/sensor inputs on the board. Each input is synchronised and debounced. A warning indicator is driven from a maskable subset of inputs, and a critical indicator from a second subset. The critical indicator blinks while the fault is live and stays steadily lit, latched, after the fault clears until the operator acknowledges it. Sits between board switches/buttons and the LED pins; no other block depends on it.

Parameters:
N_SW, 5, number of input channels (1..16)
WARN_MASK, 5'b10011, bit i set: debounced sw[i] contributes to warning
CRIT_MASK, 5'b01100, bit i set: debounced sw[i] contributes to critical
DB_CYCLES, 4, consecutive stable cycles required to accept a new input level (>=1)
BLINK_HALF, 3, cycles per blink half-period (>=1)
CNT_W, 4, width of critical-event counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sw  input  N_SW  raw asynchronous switch inputs
ack  input  1  operator acknowledge (level, sampled each clock, already debounced upstream)
led  output  2  led[0] = warning, led[1] = critical
crit_state  output  2  current critical FSM state (IDLE=0, ACTIVE=1, HELD=2)
crit_count  output  CNT_W  saturating count of IDLE/HELD -> ACTIVE entries

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values:
  - sync flops, debounced values, debounce counters: 0
  - led = 2'b00
  - crit_state = IDLE
  - crit_count = 0
  - blink counter and blink phase: 0
- Reset asserted mid-operation overrides everything on that edge, including a pending latch or blink.
- Per channel: 2-flop synchroniser, then debounce.
  - Counter increments while sync != db.
  - Counter clears whenever sync == db.
  - When the counter reaches DB_CYCLES-1 with sync still != db, db <= sync and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never reaches db.
- warn = |(db & WARN_MASK); crit = |(db & CRIT_MASK). Both are combinational from db.
- led[0] is registered: led[0] <= warn. Latency from the first clock edge sampling a new stable sw level to the led[0] change is 2 + DB_CYCLES + 1 cycles.
- Critical FSM, registered:
  - IDLE: crit=1 -> ACTIVE, crit_count += 1 (saturating at all-ones).
  - ACTIVE: crit=0 -> HELD. ack is ignored in ACTIVE.
  - HELD: crit=1 -> ACTIVE, crit_count += 1. Otherwise ack=1 -> IDLE.
  - HELD with crit=1 and ack=1 on the same edge: crit wins, go to ACTIVE.
- Blink generator:
  - Counter and phase are cleared on the edge entering ACTIVE; phase starts at 1.
  - In ACTIVE, the counter counts 0..BLINK_HALF-1, then wraps to 0 and toggles phase.
  - The counter is held at 0 outside ACTIVE.
- led[1] (registered) per state:
  - IDLE: 0
  - ACTIVE: phase; the first BLINK_HALF cycles after entry are on.
  - HELD: 1 steady.
- crit_state output equals the registered FSM state.
- Masks wider than N_SW are truncated to N_SW bits. Mask bits that are 0 fully ignore that channel.

Decomposition:
- Shared package dash_pkg holds:
  - crit-state enumeration IDLE/ACTIVE/HELD (2-bit)
  - LED index constants LED_WARN=0, LED_CRIT=1
- One sub-module, debounce_bit: 2-flop synchroniser plus DB_CYCLES stability counter, parameter DB_CYCLES, ports clk, rst, din, dout. Instantiated N_SW times in a generate loop.
- Top level contains the mask reduction, the critical FSM, the blink generator and the counter.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, sw=0 -> led=00, crit_state=0, crit_count=0 on every cycle.
2. Warning latency: set sw=5'b00001 steady -> led[0] rises exactly 7 cycles after the first sampling edge. Clear sw -> led[0] falls 7 cycles later. led[1] stays 0 throughout.
3. Glitch rejection: pulse sw[1]=1 for 3 cycles -> led[0] never asserts. Hold it for 4 cycles -> led[0] asserts.
4. Critical blink and latch:
   - Set sw=5'b00100 -> crit_state=1, crit_count=1, led[1] pattern 1,1,1,0,0,0,1,...
   - Clear sw -> crit_state=2 and led[1]=1 steady.
   - ack=1 while ACTIVE is ignored; ack=1 while HELD -> crit_state=0, led[1]=0.
5. Re-fault in HELD with simultaneous ack: in HELD, drive sw[3]=1 debounced on the same edge as ack=1 -> crit_state=1, crit_count increments, blink restarts with phase=1.
6. Saturation and reset mid-blink:
   - 17 IDLE->ACTIVE entries -> crit_count=4'hF.
   - Assert rst during ACTIVE -> next cycle led=00, crit_state=0, crit_count=0.

Source files
------------

// File: rtl/dash_pkg.sv
// dash_pkg: shared critical-state encoding and LED bit positions for the dashboard controller
package dash_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HELD = 2'd2} crit_state_e;
  localparam int LED_WARN = 0;
  localparam int LED_CRIT = 1;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchroniser followed by a DB_CYCLES stability filter
module debounce_bit #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  logic s1_q, s2_q, db_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      db_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      if (s2_q == db_q) cnt_q <= '0;
      else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_q <= s2_q;
        cnt_q <= '0;
      end else cnt_q <= cnt_q + CW'(1);
    end
  end
  assign dout = db_q;
endmodule

// File: rtl/dash_warn_ctrl.sv
// dash_warn_ctrl: debounced switch inputs drive a warning LED and a blinking, latched critical LED
module dash_warn_ctrl
  import dash_pkg::*;
#(
  parameter int          N_SW       = 5,
  parameter logic [15:0] WARN_MASK  = 16'b10011,
  parameter logic [15:0] CRIT_MASK  = 16'b01100,
  parameter int          DB_CYCLES  = 4,
  parameter int          BLINK_HALF = 3,
  parameter int          CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SW-1:0]  sw,
  input  logic             ack,
  output logic [1:0]       led,
  output logic [1:0]       crit_state,
  output logic [CNT_W-1:0] crit_count
);
  localparam int BW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  localparam logic [N_SW-1:0] WM = WARN_MASK[N_SW-1:0];
  localparam logic [N_SW-1:0] CM = CRIT_MASK[N_SW-1:0];
  logic [N_SW-1:0] db;
  logic warn, crit, phase_q;
  logic [1:0] led_q;
  logic [BW-1:0] bcnt_q;
  logic [CNT_W-1:0] count_q;
  crit_state_e state_q;
  for (genvar g = 0; g < N_SW; g++) begin : g_db
    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (.clk(clk), .rst(rst), .din(sw[g]), .dout(db[g]));
  end
  assign warn = |(db & WM);
  assign crit = |(db & CM);
  // led[CRIT] is written alongside the state so it always matches the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      bcnt_q <= '0;
      phase_q <= 1'b0;
      led_q <= 2'b00;
    end else begin
      led_q[LED_WARN] <= warn;
      if (state_q == ACTIVE) begin
        if (!crit) begin
          state_q <= HELD;
          bcnt_q <= '0;
          led_q[LED_CRIT] <= 1'b1;
        end else if (bcnt_q == BW'(BLINK_HALF - 1)) begin
          bcnt_q <= '0;
          phase_q <= ~phase_q;
          led_q[LED_CRIT] <= ~phase_q;
        end else bcnt_q <= bcnt_q + BW'(1);
      end else if (crit) begin
        state_q <= ACTIVE;
        if (~&count_q) count_q <= count_q + CNT_W'(1);
        bcnt_q <= '0;
        phase_q <= 1'b1;
        led_q[LED_CRIT] <= 1'b1;
      end else if (state_q == HELD && ack) begin
        state_q <= IDLE;
        led_q[LED_CRIT] <= 1'b0;
      end
    end
  end
  assign led = led_q;
  assign crit_state = state_q;
  assign crit_count = count_q;
endmodule

// File: tb/tb_dash_warn_ctrl.sv
// tb_dash_warn_ctrl: directed-vector self-checking bench for dash_warn_ctrl
module tb_dash_warn_ctrl;
  logic clk = 1'b0;
  logic rst, ack;
  logic [4:0] sw;
  logic [1:0] led, crit_state;
  logic [3:0] crit_count;
  int n_chk = 0;
  int n_fail = 0;
  dash_warn_ctrl dut (
    .clk(clk), .rst(rst), .sw(sw), .ack(ack),
    .led(led), .crit_state(crit_state), .crit_count(crit_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic enter_held_then_idle(input int exp_cnt);
    sw = 5'b00100;
    step(7);
    check("loop_state_active", crit_state, 1);
    check("loop_count", crit_count, exp_cnt);
    sw = 5'b00000;
    step(7);
    check("loop_state_held", crit_state, 2);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("loop_state_idle", crit_state, 0);
  endtask
  int pat[7] = '{1, 1, 1, 0, 0, 0, 1};
  initial begin
    rst = 1'b1;
    sw = '0;
    ack = 1'b0;
    repeat (2) begin
      step(1);
      check("rst_led", led, 0);
      check("rst_state", crit_state, 0);
      check("rst_count", crit_count, 0);
    end
    rst = 1'b0;
    step(1);
    check("idle_led", led, 0);
    // warning latency: 7 edges from the first sampling edge
    sw = 5'b00001;
    step(6);
    check("warn_pre_rise", led, 0);
    step(1);
    check("warn_rise", led, 1);
    sw = 5'b00000;
    step(6);
    check("warn_pre_fall", led, 1);
    step(1);
    check("warn_fall", led, 0);
    // glitch rejection, then an accepted 4-cycle pulse
    sw = 5'b00010;
    step(3);
    sw = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch_led0", led[0], 0);
    end
    sw = 5'b00010;
    step(4);
    sw = 5'b00000;
    step(3);
    check("pulse4_led0", led[0], 1);
    step(5);
    check("pulse4_cleared", led[0], 0);
    // critical blink and latch
    sw = 5'b00100;
    step(6);
    check("crit_pre_state", crit_state, 0);
    step(1);
    check("crit_state_active", crit_state, 1);
    check("crit_count_1", crit_count, 1);
    check("crit_led0", led[0], 0);
    check("blink_0", led[1], pat[0]);
    ack = 1'b1;
    for (int i = 1; i < 7; i++) begin
      step(1);
      check("blink", led[1], pat[i]);
      check("ack_ignored_active", crit_state, 1);
    end
    ack = 1'b0;
    sw = 5'b00000;
    step(7);
    check("held_state", crit_state, 2);
    check("held_led1", led[1], 1);
    step(3);
    check("held_steady_state", crit_state, 2);
    check("held_steady_led1", led[1], 1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("ack_idle_state", crit_state, 0);
    check("ack_idle_led1", led[1], 0);
    // re-fault in HELD coinciding with ack
    sw = 5'b00100;
    step(7);
    check("refault_active", crit_state, 1);
    check("refault_count_2", crit_count, 2);
    sw = 5'b00000;
    step(7);
    check("refault_held", crit_state, 2);
    sw = 5'b01000;
    step(6);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("crit_wins_state", crit_state, 1);
    check("crit_wins_count", crit_count, 3);
    check("crit_wins_led1", led[1], 1);
    step(3);
    check("restart_phase_off", led[1], 0);
    sw = 5'b00000;
    step(7);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("back_idle", crit_state, 0);
    // saturation: 14 more entries brings the total to 17
    for (int i = 0; i < 14; i++) enter_held_then_idle((4 + i > 15) ? 15 : 4 + i);
    check("sat_count", crit_count, 15);
    sw = 5'b00100;
    step(7);
    check("sat_active", crit_state, 1);
    check("sat_hold", crit_count, 15);
    step(1);
    rst = 1'b1;
    step(1);
    check("midrst_led", led, 0);
    check("midrst_state", crit_state, 0);
    check("midrst_count", crit_count, 0);
    rst = 1'b0;
    sw = 5'b00000;
    step(2);
    check("post_rst_led", led, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
